mem_burst_responder: RTL and testbench

MEM_BURST_RESPONDER -- requirements
Module: mem_burst_responder

---
 rtl/mem_burst_responder.sv | 134 +++++++++++++
 tb/tb_mem_burst_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_responder.sv
// Backing-store memory responder: line-fill read bursts and single-word writes with configurable latency.
// Optional build macro MEM_CRITICAL_WORD_FIRST_EN starts read bursts at the requested word and wraps.
module mem_burst_responder #(
  parameter int ADR_WIDTH      = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WORD_OFFSET    = 2,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int LATENCY        = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_cc2mem,
  input  logic [ADR_WIDTH-1:0]   adr_cc2mem,
  input  logic                   rdwr_cc2mem,
  input  logic [DATA_WIDTH-1:0]  dat_cc2mem,
  output logic                   ack_mem2cc,
  output logic [DATA_WIDTH-1:0]  dat_mem2cc,
  output logic [WORD_OFFSET-1:0] word_mem2mshr
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    BEAT,
    GAP,
    DONE
  } state_t;

  state_t                    state;
  logic [3:0]                cnt;
  logic [MEM_DEPTH_LOG2-1:0] adr_q;
  logic                      rdwr_q;
  logic [DATA_WIDTH-1:0]     dat_q;
  logic [WORD_OFFSET-1:0]    beat_cnt;
  logic [WORD_OFFSET-1:0]    start_word;
  logic [WORD_OFFSET-1:0]    beat_word;
  logic [MEM_DEPTH_LOG2-1:0] rd_idx;
  logic                      mem_we;

  logic [DATA_WIDTH-1:0] mem [0:(1 << MEM_DEPTH_LOG2)-1];

  // Byte-lane and above-depth address bits alias away by design.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{adr_cc2mem[ADR_WIDTH-1:MEM_DEPTH_LOG2+2], adr_cc2mem[1:0]};

`ifdef MEM_CRITICAL_WORD_FIRST_EN
  assign start_word = adr_q[WORD_OFFSET-1:0];
`else
  assign start_word = '0;
`endif

  always_comb begin
    beat_word = start_word + beat_cnt;
    rd_idx    = {adr_q[MEM_DEPTH_LOG2-1:WORD_OFFSET], beat_word};
    mem_we    = (state == WAIT) && req_cc2mem && (cnt == '0) && rdwr_q;
  end

  // Store is deliberately outside the reset domain so contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[adr_q] <= dat_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      adr_q         <= '0;
      rdwr_q        <= 1'b0;
      dat_q         <= '0;
      beat_cnt      <= '0;
      ack_mem2cc    <= 1'b0;
      dat_mem2cc    <= '0;
      word_mem2mshr <= '0;
    end else begin
      ack_mem2cc <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_cc2mem) begin
            adr_q    <= adr_cc2mem[MEM_DEPTH_LOG2+1:2];
            rdwr_q   <= rdwr_cc2mem;
            dat_q    <= dat_cc2mem;
            cnt      <= 4'(LATENCY);
            beat_cnt <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (!req_cc2mem) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt == '0) begin
            state      <= BEAT;
            ack_mem2cc <= 1'b1;
            if (!rdwr_q) begin
              dat_mem2cc    <= mem[rd_idx];
              word_mem2mshr <= beat_word;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        BEAT: begin
          if (!req_cc2mem) begin
            state <= IDLE;
          end else if (rdwr_q || (beat_cnt == '1)) begin
            state <= DONE;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
            state    <= GAP;
          end
        end
        GAP: begin
          if (!req_cc2mem) begin
            state <= IDLE;
          end else begin
            state         <= BEAT;
            ack_mem2cc    <= 1'b1;
            dat_mem2cc    <= mem[rd_idx];
            word_mem2mshr <= beat_word;
          end
        end
        DONE: begin
          if (!req_cc2mem) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_burst_responder.sv
// Directed bench for mem_burst_responder: a transaction-level model checked every cycle plus literal beat checks.
module tb_mem_burst_responder;

  localparam int LAT = 2;

  logic        clk;
  logic        rst;
  logic        req;
  logic [31:0] adr;
  logic        rdwr;
  logic [31:0] din;
  logic        ack;
  logic [31:0] dout;
  logic [1:0]  word;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 0;

  mem_burst_responder #(
    .ADR_WIDTH(32),
    .DATA_WIDTH(32),
    .WORD_OFFSET(2),
    .MEM_DEPTH_LOG2(10),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_cc2mem(req),
    .adr_cc2mem(adr),
    .rdwr_cc2mem(rdwr),
    .dat_cc2mem(din),
    .ack_mem2cc(ack),
    .dat_mem2cc(dout),
    .word_mem2mshr(word)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: a transaction is a fixed schedule of beats counted in edges from acceptance.
  logic [31:0] mmem [0:1023];
  bit          m_busy;
  int          m_t;
  logic [31:0] m_adr;
  logic        m_wr;
  logic [31:0] m_d;
  logic        exp_ack;
  logic [31:0] exp_dat;
  logic [1:0]  exp_word;

  task automatic model_step();
    int k, nb, widx, w;
    if (rst) begin
      m_busy = 0; exp_ack = 0; exp_dat = 0; exp_word = 0;
    end else if (!m_busy) begin
      exp_ack = 0;
      if (req) begin
        m_busy = 1; m_t = 0; m_adr = adr; m_wr = rdwr; m_d = din;
      end
    end else begin
      m_t++;
      exp_ack = 0;
      if (!req) begin
        m_busy = 0;
      end else begin
        k  = m_t - (LAT + 1);
        nb = m_wr ? 1 : 4;
        if (k >= 0 && k % 2 == 0 && k / 2 < nb) begin
          exp_ack = 1;
          widx = int'((m_adr >> 2) & 32'h3FF);
          if (m_wr) begin
            mmem[widx] = m_d;
          end else begin
`ifdef MEM_CRITICAL_WORD_FIRST_EN
            w = (int'(m_adr >> 2) + k / 2) % 4;
`else
            w = k / 2;
`endif
            exp_word = 2'(w);
            exp_dat  = mmem[(widx & ~3) | w];
          end
        end
      end
    end
  endtask

  initial begin
    m_busy = 0; exp_ack = 0; exp_dat = 0; exp_word = 0;
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("ack", 32'(ack), 32'(exp_ack));
      chk("dat", dout, exp_dat);
      chk("word", 32'(word), 32'(exp_word));
    end
  end

  int          beat_e[$];
  logic [31:0] beat_dat[$];
  logic [1:0]  beat_word[$];

  // Holds the request for ncyc edges after acceptance, recording each beat's edge index.
  task automatic txn(input logic [31:0] a, input logic w, input logic [31:0] d,
                     input int ncyc, input bit scramble);
    @(negedge clk);
    req = 1'b1; adr = a; rdwr = w; din = d; rst = 1'b0;
    beat_e.delete(); beat_dat.delete(); beat_word.delete();
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      if (ack) begin
        beat_e.push_back(i - 1);
        beat_dat.push_back(dout);
        beat_word.push_back(word);
      end
      if (scramble && i == 1) begin
        adr = 32'hFFFF_FFF0; rdwr = ~w; din = 32'h5555_5555;
      end
    end
    req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ew[4];
    int extra;
    req = 0; adr = 0; rdwr = 0; din = 0; rst = 0;
    #1 rst = 1;
    started = 1;
    repeat (3) @(negedge clk);
    chk("reset_ack", 32'(ack), 32'd0);
    chk("reset_dat", dout, 32'd0);
    chk("reset_word", 32'(word), 32'd0);
    rst = 0;

    for (int i = 0; i < 4; i++) begin
      txn(32'h100 + 32'(4 * i), 1'b1, 32'hAAAA_0000 + 32'(i), 4, 0);
      chk("wr_nacks", 32'(beat_e.size()), 32'd1);
      if (beat_e.size() > 0) chk("wr_first_edge", 32'(beat_e[0]), 32'(LAT + 1));
    end

    txn(32'h104, 1'b1, 32'hDEAD_BEEF, 2, 0);
    chk("wr_abort_nacks", 32'(beat_e.size()), 32'd0);

`ifdef MEM_CRITICAL_WORD_FIRST_EN
    ew = '{2, 3, 0, 1};
`else
    ew = '{0, 1, 2, 3};
`endif
    txn(32'h108, 1'b0, 32'h0, 10, 0);
    chk("rd108_nbeats", 32'(beat_e.size()), 32'd4);
    for (int i = 0; i < beat_e.size() && i < 4; i++) begin
      chk("rd108_edge", 32'(beat_e[i]), 32'(3 + 2 * i));
      chk("rd108_word", 32'(beat_word[i]), 32'(ew[i]));
      chk("rd108_dat", beat_dat[i], 32'hAAAA_0000 + 32'(ew[i]));
    end

    txn(32'h100, 1'b0, 32'h0, 16, 0);
    chk("hold_nacks", 32'(beat_e.size()), 32'd4);

    txn(32'h10C, 1'b0, 32'h0, 10, 0);
    chk("reaccept_nbeats", 32'(beat_e.size()), 32'd4);
    if (beat_e.size() > 0) chk("reaccept_first_edge", 32'(beat_e[0]), 32'd3);

    txn(32'h100, 1'b0, 32'h0, 6, 0);
    chk("abort_nbeats", 32'(beat_e.size()), 32'd2);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack) extra++;
    end
    chk("abort_extra_acks", 32'(extra), 32'd0);
    txn(32'h100, 1'b0, 32'h0, 10, 0);
    chk("after_abort_nbeats", 32'(beat_e.size()), 32'd4);

    txn(32'h100, 1'b0, 32'h0, 10, 1);
    chk("scramble_nbeats", 32'(beat_e.size()), 32'd4);
    for (int i = 0; i < beat_e.size() && i < 4; i++)
      chk("scramble_dat", beat_dat[i], 32'hAAAA_0000 + 32'(i));

    txn(32'hABCD_1103, 1'b0, 32'h0, 10, 0);
    chk("alias_nbeats", 32'(beat_e.size()), 32'd4);
    if (beat_dat.size() == 4) chk("alias_dat3", beat_dat[3], 32'hAAAA_0003);

    @(negedge clk);
    req = 1; adr = 32'h108; rdwr = 0;
    repeat (4) @(negedge clk);
    #1 rst = 1;
    #1;
    chk("rst_mid_ack", 32'(ack), 32'd0);
    chk("rst_mid_dat", dout, 32'd0);
    chk("rst_mid_word", 32'(word), 32'd0);
    req = 0;
    repeat (2) @(negedge clk);
    req = 1; adr = 32'h100; rdwr = 0;
    txn(32'h100, 1'b0, 32'h0, 10, 0);
    chk("post_rst_nbeats", 32'(beat_e.size()), 32'd4);
    if (beat_e.size() > 0) chk("post_rst_first_edge", 32'(beat_e[0]), 32'd3);
    if (beat_dat.size() > 1) chk("post_rst_dat1", beat_dat[1], 32'hAAAA_0001);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
